ddr3_pg_arb: RTL and testbench

DDR3_PG_ARB -- requirements
Module: ddr3_pg_arb

---
 rtl/pg_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 27 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/ddr3_pg_arb.sv | 158 +++++++++++++++
 tb/tb_ddr3_pg_arb.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pg_arb_pkg.sv
// Shared definitions for the DDR3 page-transfer arbiter: FSM encoding,
// default page-address width and grant index width.
package pg_arb_pkg;

    localparam int PG_ADDR_W_DEF = 28;
    localparam int GID_W         = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first set req bit found
// circularly starting at rr_ptr+1.
module rr_pick
    import pg_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GID_W-1:0] rr_ptr,
    output logic             valid,
    output logic [GID_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid && req[i] && (i == ((int'(rr_ptr) + k) % N_REQ))) begin
                    valid = 1'b1;
                    idx   = GID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer cell for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ddr3_pg_arb.sv
// DDR3 page-transfer arbiter: N_REQ 4-phase requesters share one page engine.
// Optional macro PG_ARB_PRIORITY_EN gives requester 0 strict priority.
module ddr3_pg_arb
    import pg_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PG_ADDR_W = PG_ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           optype,
    input  logic [N_REQ*PG_ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]           ack,
    output logic                       pg_req,
    output logic                       pg_optype,
    output logic [PG_ADDR_W-1:0]       pg_addr,
    input  logic                       pg_ack,
    output logic [GID_W-1:0]           grant_id,
    output logic                       busy,
    output logic [31:0]                grant_cnt,
    output logic                       proto_err,
    output state_t                     dbg_state
);

    // Handshakes are 4-phase level protocols on both sides: a requester holds
    // req until it sees ack, then drops req; ack drops only after req and the
    // synchronized engine acknowledge are both low. The engine side mirrors
    // this with pg_req/pg_ack, and pg_addr/pg_optype are stable while pg_req=1.

    state_t                 state, state_nxt;
    logic [GID_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic                   pg_req_nxt, pg_optype_nxt, proto_err_nxt;
    logic [PG_ADDR_W-1:0]   pg_addr_nxt;
    logic [N_REQ-1:0]       ack_nxt;
    logic [GID_W-1:0]       grant_id_nxt;
    logic [31:0]            grant_cnt_nxt;

    logic                   pg_ack_s;
    logic [N_REQ-1:0]       pick_req;
    logic                   pick_valid, win_valid;
    logic [GID_W-1:0]       pick_idx, win_idx;
    logic [PG_ADDR_W-1:0]   sel_addr;
    logic                   sel_optype;
    logic [N_REQ-1:0]       gnt_oh;
    logic                   req_gnt;

    sync_2ff u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pg_ack),
        .q     (pg_ack_s)
    );

`ifdef PG_ARB_PRIORITY_EN
    // Requester 0 bypasses the rotation; the rest share the round-robin pool.
    assign pick_req  = req & {{(N_REQ-1){1'b1}}, 1'b0};
    assign win_valid = req[0] | pick_valid;
    assign win_idx   = req[0] ? '0 : pick_idx;
`else
    assign pick_req  = req;
    assign win_valid = pick_valid;
    assign win_idx   = pick_idx;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (pick_req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        sel_addr   = '0;
        sel_optype = 1'b0;
        gnt_oh     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == GID_W'(i)) begin
                sel_addr   = addr[i*PG_ADDR_W +: PG_ADDR_W];
                sel_optype = optype[i];
            end
            gnt_oh[i] = (grant_id == GID_W'(i));
        end
    end

    assign req_gnt = |(req & gnt_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= GID_W'(N_REQ - 1);
            pg_req    <= 1'b0;
            pg_optype <= 1'b0;
            pg_addr   <= '0;
            ack       <= '0;
            grant_id  <= '0;
            grant_cnt <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            pg_req    <= pg_req_nxt;
            pg_optype <= pg_optype_nxt;
            pg_addr   <= pg_addr_nxt;
            ack       <= ack_nxt;
            grant_id  <= grant_id_nxt;
            grant_cnt <= grant_cnt_nxt;
            proto_err <= proto_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        pg_req_nxt    = pg_req;
        pg_optype_nxt = pg_optype;
        pg_addr_nxt   = pg_addr;
        ack_nxt       = ack;
        grant_id_nxt  = grant_id;
        grant_cnt_nxt = grant_cnt;
        // An engine acknowledge with nothing outstanding is a protocol fault.
        proto_err_nxt = proto_err | ((state == S_IDLE) && pg_ack_s);
        case (state)
            S_IDLE: begin
                if (arb_en && win_valid) begin
                    pg_req_nxt    = 1'b1;
                    pg_optype_nxt = sel_optype;
                    pg_addr_nxt   = sel_addr;
                    grant_id_nxt  = win_idx;
                    state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pg_ack_s) begin
                    pg_req_nxt = 1'b0;
                    ack_nxt    = gnt_oh;
                    state_nxt  = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!pg_ack_s && !req_gnt) begin
                    ack_nxt       = '0;
                    grant_cnt_nxt = grant_cnt + 32'd1;
                    rr_ptr_nxt    = grant_id;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ddr3_pg_arb.sv
// Self-checking bench for ddr3_pg_arb with a 4-phase engine and requester model.
module tb_ddr3_pg_arb;
    import pg_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 28;

    logic              clk;
    logic              rst_n;
    logic              arb_en;
    logic [N-1:0]      req;
    logic [N-1:0]      optype;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      ack;
    logic              pg_req;
    logic              pg_optype;
    logic [AW-1:0]     pg_addr;
    logic              pg_ack;
    logic [GID_W-1:0]  grant_id;
    logic              busy;
    logic [31:0]       grant_cnt;
    logic              proto_err;
    state_t            dbg_state;

    ddr3_pg_arb #(.N_REQ(N), .PG_ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req       (req),
        .optype    (optype),
        .addr      (addr),
        .ack       (ack),
        .pg_req    (pg_req),
        .pg_optype (pg_optype),
        .pg_addr   (pg_addr),
        .pg_ack    (pg_ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .grant_cnt (grant_cnt),
        .proto_err (proto_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [GID_W-1:0] exp_q[$];
    int               n_cmp;
    int               n_err;
    logic [31:0]      exp_cnt;
    int               req_left[N];
    logic [AW-1:0]    cur_addr[N];
    logic             cur_op[N];
    int               ack_cyc[N];
    logic [AW-1:0]    lat_addr;
    logic             lat_op;
    logic             pg_req_q;
    logic             eng_en;
    int               eng_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [GID_W-1:0] e;
        if (pg_req && !pg_req_q) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_id", 64'(grant_id), 64'(e));
                check("pg_addr", 64'(pg_addr), 64'(cur_addr[e]));
                check("pg_optype", 64'(pg_optype), 64'(cur_op[e]));
                lat_addr = cur_addr[e];
                lat_op   = cur_op[e];
            end else begin
                check("grant_extra", 64'(exp_q.size()), 64'd1);
            end
        end else if (pg_req) begin
            check("addr_hold", 64'(pg_addr), 64'(lat_addr));
            check("op_hold", 64'(pg_optype), 64'(lat_op));
        end
        if (ack != '0) begin
            check("ack_onehot", 64'($countones(ack)), 64'd1);
            check("ack_state", 64'(dbg_state), 64'(S_WAIT_REL));
            for (int i = 0; i < N; i++) if (ack[i]) ack_cyc[i]++;
        end
        pg_req_q = pg_req;
    endtask

    // engine model: raise pg_ack after a random delay, drop it once pg_req falls
    task automatic engine();
        if (!eng_en) return;
        if (pg_req && !pg_ack) begin
            if (eng_wait == 0) begin
                pg_ack   = 1'b1;
                eng_wait = $urandom_range(0, 3);
            end else begin
                eng_wait--;
            end
        end else if (!pg_req && pg_ack) begin
            pg_ack = 1'b0;
        end
    endtask

    task automatic requesters();
        for (int i = 0; i < N; i++) begin
            if (ack[i] && req[i]) begin
                req[i] = 1'b0;
                addr[i*AW +: AW] = AW'($urandom);
                optype[i] = ~optype[i];
            end else if (!ack[i] && !req[i] && req_left[i] > 0) begin
                cur_addr[i] = AW'($urandom);
                cur_op[i]   = 1'($urandom_range(0, 1));
                addr[i*AW +: AW] = cur_addr[i];
                optype[i] = cur_op[i];
                req[i] = 1'b1;
                req_left[i]--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        engine();
        requesters();
    endtask

    task automatic wait_cnt(input string tag);
        for (int i = 0; i < 400 && grant_cnt != exp_cnt; i++) step();
        check(tag, 64'(grant_cnt), 64'(exp_cnt));
        check("q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_pg_req(input string tag);
        for (int i = 0; i < 50 && !pg_req; i++) step();
        check(tag, 64'(pg_req), 64'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; exp_cnt = '0;
        rst_n = 1'b0; arb_en = 1'b1; req = '0; optype = '0; addr = '0;
        pg_ack = 1'b0; eng_en = 1'b1; eng_wait = 0; pg_req_q = 1'b0;
        lat_addr = '0; lat_op = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_left[i] = 0; cur_addr[i] = '0; cur_op[i] = 1'b0; ack_cyc[i] = 0;
        end

        // reset values
        repeat (2) @(negedge clk);
        check("rst_pg_req", 64'(pg_req), 64'd0);
        check("rst_pg_optype", 64'(pg_optype), 64'd0);
        check("rst_pg_addr", 64'(pg_addr), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;

        // contention: all four request, requester 0 comes back once more
        req_left = '{2, 1, 1, 1};
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        exp_cnt += 5;
        wait_cnt("contention_cnt");

        // single request with a fixed address, then scramble after the latch
        step();
        cur_addr[2] = 28'h0001000; cur_op[2] = 1'b1;
        addr[2*AW +: AW] = 28'h0001000; optype[2] = 1'b1; req[2] = 1'b1;
        exp_q.push_back(3'd2);
        exp_cnt += 1;
        ack_cyc[2] = 0;
        step();
        check("single_pg_req_lat", 64'(pg_req), 64'd1);
        check("single_pg_addr", 64'(pg_addr), 64'h0001000);
        addr[2*AW +: AW] = 28'hFFFFFFF; optype[2] = 1'b0;
        step();
        check("single_addr_ignored", 64'(pg_addr), 64'h0001000);
        wait_cnt("single_cnt");
        check("single_ack_seen", 64'(ack_cyc[2] > 0), 64'd1);

        // arb_en low blocks a new grant; clearing it mid-flight does not abort
        arb_en = 1'b0;
        req_left[3] = 1;
        exp_q.push_back(3'd3);
        exp_cnt += 1;
        repeat (6) step();
        check("arb_dis_pg_req", 64'(pg_req), 64'd0);
        check("arb_dis_busy", 64'(busy), 64'd0);
        arb_en = 1'b1;
        wait_pg_req("arb_en_pg_req");
        arb_en = 1'b0;
        wait_cnt("arb_inflight_cnt");
        arb_en = 1'b1;
        req_left[0] = 1;
        exp_q.push_back(3'd0);
        exp_cnt += 1;
        wait_cnt("arb_reen_cnt");

        // early drop of req during S_ISSUE
        ack_cyc[1] = 0;
        req_left[1] = 1;
        exp_q.push_back(3'd1);
        exp_cnt += 1;
        wait_pg_req("early_pg_req");
        check("early_state", 64'(dbg_state), 64'(S_ISSUE));
        req[1] = 1'b0;
        wait_cnt("early_cnt");
        check("early_ack_min", 64'(ack_cyc[1] >= 1), 64'd1);
        check("early_idle", 64'(dbg_state), 64'(S_IDLE));

        // reset in the middle of a transfer
        req_left[2] = 1;
        exp_q.push_back(3'd2);
        wait_pg_req("mid_pg_req");
        check("mid_busy_pre", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pg_req", 64'(pg_req), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
        check("mid_rst_cnt", 64'(grant_cnt), 64'd0);
        req = '0;
        for (int i = 0; i < N; i++) req_left[i] = 0;
        exp_cnt = '0;
        repeat (3) step();
        rst_n = 1'b1;
        check("mid_rst_proto", 64'(proto_err), 64'd0);
        // rr_ptr back at N-1: requester 0 must beat requester 3
        req_left[0] = 1; req_left[3] = 1;
        exp_q.push_back(3'd0); exp_q.push_back(3'd3);
        exp_cnt += 2;
        wait_cnt("post_rst_cnt");

        // requester 0 re-requesting against 1 and 2
        req_left = '{3, 1, 1, 0};
`ifdef PG_ARB_PRIORITY_EN
        exp_q.push_back(3'd0); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2);
`else
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        exp_q.push_back(3'd0); exp_q.push_back(3'd0);
`endif
        exp_cnt += 5;
        wait_cnt("prio_cnt");

        // stray engine acknowledge while idle
        step();
        eng_en = 1'b0;
        pg_ack = 1'b1;
        step();
        step();
        check("stray_proto_early", 64'(proto_err), 64'd0);
        step();
        check("stray_proto_set", 64'(proto_err), 64'd1);
        pg_ack = 1'b0;
        repeat (5) step();
        check("stray_proto_sticky", 64'(proto_err), 64'd1);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_cnt", 64'(grant_cnt), 64'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
